calc_res_reader: RTL and testbench
==================================

CALC_RES_READER -- requirements
Module: calc_res_reader

Interface
REQ-001 SHALL have parameter RES_NUM, default 1000, the number of result words read per frame.
REQ-002 SHALL have parameter PARK_ADDR, default 10'd1000, the idle address that signals "readout complete" to the result cache.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the output FIFO depth in words.
REQ-004 SHALL have port clk_200M  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rd_start  in  1  one-cycle pulse requesting a frame readout (driven by calc_finish_pulse).
REQ-007 SHALL have port calc_res_out  in  32  result RAM read data, valid exactly 2 cycles after the address is presented.
REQ-008 SHALL have ports calc_fps, calc_use_part and calc_total_part, each  in  32  statistics words.
REQ-009 SHALL have port calc_res_ram_addr  out  10  result RAM read address.
REQ-010 SHALL have port m_tdata  out  32  stream data.
REQ-011 SHALL have port m_tvalid  out  1  stream valid.
REQ-012 SHALL have port m_tready  in  1  stream ready.
REQ-013 SHALL have port m_tlast  out  1  high on the final word of a frame.
REQ-014 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-015 SHALL have port frame_cnt  out  16  count of completed frames.
REQ-016 SHALL have port overrun  out  1  sticky flag for a rd_start rejected while busy.

Function
REQ-017 SHALL implement the FSM IDLE -> HDR -> RD -> DRAIN -> DONE -> IDLE.
- DONE lasts exactly 1 cycle.
REQ-018 SHALL accept rd_start only in IDLE.
- On acceptance: latch the header words H0 = 32'hCA1C_0000 | frame_cnt, H1 = calc_fps, H2 = calc_use_part, H3 = calc_total_part.
- Enter HDR.
REQ-019 SHALL handle rd_start in any state other than IDLE as follows: ignore it, set overrun = 1, and leave the stream unaffected; overrun is cleared only by reset.
REQ-020 SHALL, in HDR, push H0..H3 into the FIFO one per cycle, in order, when the FIFO is not full, then enter RD.
REQ-021 SHALL, in RD, issue addresses 0 .. RES_NUM-1 in ascending order.
- An address issues only when fifo_count + inflight < FIFO_DEPTH.
- inflight is the number of issued reads whose data has not yet returned (0..2).
REQ-022 SHALL push each read return into the FIFO exactly 2 cycles after issue.
- The credit rule guarantees no FIFO overflow; a push into a full FIFO is a design error that the bench asserts against.
REQ-023 SHALL hold calc_res_ram_addr at its last issued value while stalled.
- After issuing RES_NUM-1, enter DRAIN and hold the address at RES_NUM-1.
REQ-024 SHALL leave DRAIN when inflight = 0 and the FIFO is empty with the final word accepted (m_tvalid & m_tready & m_tlast).
REQ-025 SHALL, in DONE, drive calc_res_ram_addr = PARK_ADDR and increment frame_cnt, wrapping 16'hFFFF -> 0.
REQ-026 SHALL hold calc_res_ram_addr = PARK_ADDR in IDLE.
- The address shall never equal PARK_ADDR between acceptance of rd_start and DONE.
REQ-027 SHALL drive the stream from the FIFO head as follows: m_tvalid = FIFO not empty; a pop occurs on m_tvalid & m_tready.
- m_tdata and m_tvalid shall not change while m_tvalid = 1 and m_tready = 0.
REQ-028 SHALL assert m_tlast only on data word RES_NUM-1, which is frame word RES_NUM+3.
REQ-029 SHALL, with m_tready held at 1, sustain 1 word/cycle from the first data word to the last data word, with no bubbles.
REQ-030 SHALL allow a simultaneous FIFO push and pop in the same cycle, including when the FIFO is full, when a pop frees the slot.
REQ-031 SHALL perform all arithmetic unsigned, with the address counter 10 bits wide; RES_NUM shall be <= 1023.

Reset
REQ-032 SHALL, on rst_n = 0, immediately (asynchronously) apply: state = IDLE, calc_res_ram_addr = PARK_ADDR, m_tvalid = 0, m_tlast = 0, m_tdata = 0, busy = 0, frame_cnt = 0, overrun = 0, FIFO empty, inflight = 0.
REQ-033 SHALL, on reset mid-frame, discard all partial frame state; the next frame starts cleanly with H0 = 32'hCA1C_0000.

Verification
REQ-034 SHALL cover: release reset, no stimulus -> addr = 1000, m_tvalid = 0, busy = 0, frame_cnt = 0 for 100 cycles.
REQ-035 SHALL cover: RAM model returning addr + 32'h100 at 2-cycle latency, stats fps = 5, use = 7, total = 9, m_tready = 1, rd_start pulse -> stream CA1C_0000, 5, 7, 9, then 0x100..0x4E7; tlast on word 1003 only; data words back-to-back; addr returns to 1000; frame_cnt = 1.
REQ-036 SHALL cover: random m_tready at 50% -> identical 1004-word sequence, no loss or duplication, FIFO never overflows, data stable while stalled.
REQ-037 SHALL cover: m_tready = 0 for 200 cycles after start -> m_tvalid = 1, at most 4 words queued, addr frozen; releasing m_tready -> frame completes correctly.
REQ-038 SHALL cover: second rd_start at data word 500 -> overrun = 1, the frame continues unchanged, frame_cnt = 1 at the end.
REQ-039 SHALL cover: rst_n asserted at data word 300 -> all outputs at reset values in the same cycle; a new start yields H0 = CA1C_0000 and a full frame.

Source files
------------

// File: rtl/calc_res_reader.sv
`default_nettype none
// ============================================================================
// Module   : calc_res_reader
// Purpose  : Streams one frame per rd_start: four header words followed by
//            RES_NUM result-RAM words, credit-paced into a small output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module calc_res_reader #(
    parameter int         RES_NUM    = 1000,
    parameter logic [9:0] PARK_ADDR  = 10'd1000,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk_200M,
    input  logic        rst_n,
    input  logic        rd_start,
    input  logic [31:0] calc_res_out,
    input  logic [31:0] calc_fps,
    input  logic [31:0] calc_use_part,
    input  logic [31:0] calc_total_part,
    output logic [9:0]  calc_res_ram_addr,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        overrun
);

    localparam int              c_PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              c_CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [9:0]      c_LAST_ADDR = 10'(RES_NUM - 1);
    localparam logic [c_PW-1:0] c_PTR_MAX   = c_PW'(FIFO_DEPTH - 1);
    localparam logic [c_CW:0]   c_DEPTH     = (c_CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0]     c_H0_TAG    = 32'hCA1C_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_RD    = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    logic [31:0]           r_hdr [4];
    logic [1:0]            r_hdr_idx;
    logic [9:0]            r_rd_idx;
    logic [9:0]            r_addr;
    logic [1:0]            r_rd_pipe;
    logic [1:0]            r_last_pipe;
    logic [15:0]           r_frame_cnt;
    logic                  r_overrun;

    logic [31:0]           r_mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_mem_last;
    logic [c_PW-1:0]       r_wr_ptr;
    logic [c_PW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;

    logic                  w_valid;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_hdr_push;
    logic                  w_issue;
    logic [1:0]            w_inflight;
    logic [31:0]           w_push_data;
    logic                  w_push_last;

    function automatic logic [c_PW-1:0] f_ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_PTR_MAX) ? '0 : p + c_PW'(1);
    endfunction

    assign w_valid     = (r_count != '0);
    assign w_full      = (r_count == c_CW'(FIFO_DEPTH));
    assign w_pop       = w_valid & m_tready;
    assign w_inflight  = {1'b0, r_rd_pipe[0]} + {1'b0, r_rd_pipe[1]};
    assign w_hdr_push  = (r_state == S_HDR) && !w_full;
    // A read is only issued if its return is guaranteed a FIFO slot.
    assign w_issue     = (r_state == S_RD) &&
                         (({1'b0, r_count} + (c_CW + 1)'(w_inflight)) < c_DEPTH);
    assign w_push      = w_hdr_push | r_rd_pipe[1];
    assign w_push_data = w_hdr_push ? r_hdr[r_hdr_idx] : calc_res_out;
    assign w_push_last = ~w_hdr_push & r_last_pipe[1];

    assign m_tvalid          = w_valid;
    assign m_tdata           = w_valid ? r_mem_data[r_rd_ptr] : '0;
    assign m_tlast           = w_valid & r_mem_last[r_rd_ptr];
    assign calc_res_ram_addr = r_addr;
    assign busy              = (r_state != S_IDLE);
    assign frame_cnt         = r_frame_cnt;
    assign overrun           = r_overrun;

    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
            end
            r_mem_last <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= w_push_data;
                r_mem_last[r_wr_ptr] <= w_push_last;
                r_wr_ptr             <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                r_hdr[i] <= '0;
            end
            r_hdr_idx   <= '0;
            r_rd_idx    <= '0;
            r_addr      <= PARK_ADDR;
            r_rd_pipe   <= '0;
            r_last_pipe <= '0;
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
        end else begin
            // Read returns are sampled two edges after the issuing edge.
            r_rd_pipe   <= {r_rd_pipe[0], w_issue};
            r_last_pipe <= {r_last_pipe[0], w_issue && (r_rd_idx == c_LAST_ADDR)};

            if (rd_start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_addr <= PARK_ADDR;
                    if (rd_start) begin
                        r_hdr[0]  <= c_H0_TAG | {16'h0000, r_frame_cnt};
                        r_hdr[1]  <= calc_fps;
                        r_hdr[2]  <= calc_use_part;
                        r_hdr[3]  <= calc_total_part;
                        r_hdr_idx <= '0;
                        r_rd_idx  <= '0;
                        r_addr    <= '0;
                        r_state   <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_hdr_push) begin
                        r_hdr_idx <= r_hdr_idx + 2'd1;
                        if (r_hdr_idx == 2'd3) begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (w_issue) begin
                        r_addr   <= r_rd_idx;
                        r_rd_idx <= r_rd_idx + 10'd1;
                        if (r_rd_idx == c_LAST_ADDR) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && m_tlast && (r_count == c_CW'(1)) && (r_rd_pipe == 2'b00)) begin
                        r_addr      <= PARK_ADDR;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_addr  <= PARK_ADDR;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_addr  <= PARK_ADDR;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_res_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_calc_res_reader
// Purpose  : Directed bench with a frame-level expected-word model for
//            calc_res_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_res_reader;

    localparam int         RES_NUM     = 1000;
    localparam logic [9:0] PARK        = 10'd1000;
    localparam int         FRAME_WORDS = RES_NUM + 4;

    logic        clk_200M = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_start = 1'b0;
    logic [31:0] calc_res_out = '0;
    logic [31:0] calc_fps = '0;
    logic [31:0] calc_use_part = '0;
    logic [31:0] calc_total_part = '0;
    logic        m_tready = 1'b0;
    logic [9:0]  calc_res_ram_addr;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        overrun;

    always #2.5 clk_200M = ~clk_200M;

    calc_res_reader #(
        .RES_NUM    (RES_NUM),
        .PARK_ADDR  (PARK),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clk_200M          (clk_200M),
        .rst_n             (rst_n),
        .rd_start          (rd_start),
        .calc_res_out      (calc_res_out),
        .calc_fps          (calc_fps),
        .calc_use_part     (calc_use_part),
        .calc_total_part   (calc_total_part),
        .calc_res_ram_addr (calc_res_ram_addr),
        .m_tdata           (m_tdata),
        .m_tvalid          (m_tvalid),
        .m_tready          (m_tready),
        .m_tlast           (m_tlast),
        .busy              (busy),
        .frame_cnt         (frame_cnt),
        .overrun           (overrun)
    );

    // Synchronous-read RAM: the word for an address is sampled two edges later.
    always @(posedge clk_200M) calc_res_out <= {22'd0, calc_res_ram_addr} + 32'h100;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rdy_mode = 1;   // 0: held low, 1: held high, 2: random
    int          w_idx    = 0;
    int          exp_frames = 0;
    int          hdr_fc   = 0;
    bit          mon_en   = 0;
    logic [31:0] st_fps = 0, st_use = 0, st_tot = 0;
    logic [31:0] got [FRAME_WORDS];

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input int idx);
        case (idx)
            0:       return 32'hCA1C_0000 | (32'(hdr_fc) & 32'h0000_FFFF);
            1:       return st_fps;
            2:       return st_use;
            3:       return st_tot;
            default: return 32'h100 + 32'(idx - 4);
        endcase
    endfunction

    initial forever begin
        @(posedge clk_200M);
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    logic        prev_stall = 0;
    logic        prev_tl = 0;
    logic        prev_busy = 0;
    logic [31:0] prev_data = 0;
    logic [9:0]  prev_addr = 0;

    always @(negedge clk_200M) begin
        if (!rst_n || !mon_en) begin
            prev_stall = 0;
            prev_busy  = 0;
        end else begin
            if (prev_stall)
                check(m_tvalid === 1'b1 && m_tdata === prev_data && m_tlast === prev_tl,
                      "stall_hold", m_tdata, prev_data);
            if (busy && prev_busy && w_idx < FRAME_WORDS)
                check(calc_res_ram_addr == prev_addr || calc_res_ram_addr == 10'(prev_addr + 10'd1),
                      "addr_step", 32'(calc_res_ram_addr), 32'(prev_addr));
            if (busy && w_idx < FRAME_WORDS)
                check(calc_res_ram_addr < 10'(RES_NUM), "addr_range", 32'(calc_res_ram_addr), 32'(RES_NUM - 1));
            if (rdy_mode == 1 && w_idx > 4 && w_idx < FRAME_WORDS)
                check(m_tvalid === 1'b1, "no_bubble", 32'(m_tvalid), 32'd1);
            if (m_tvalid && m_tready) begin
                if (w_idx >= FRAME_WORDS) begin
                    check(1'b0, "extra_word", m_tdata, 32'd0);
                end else begin
                    check(m_tdata === exp_word(w_idx), "data", m_tdata, exp_word(w_idx));
                    check(m_tlast === (w_idx == FRAME_WORDS - 1), "tlast",
                          32'(m_tlast), 32'(w_idx == FRAME_WORDS - 1));
                    got[w_idx] = m_tdata;
                    w_idx++;
                    if (w_idx == FRAME_WORDS) exp_frames++;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_tl    = m_tlast;
            prev_addr  = calc_res_ram_addr;
            prev_busy  = busy;
        end
    end

    task automatic start_frame(input logic [31:0] f, input logic [31:0] u, input logic [31:0] t);
        @(posedge clk_200M);
        #1;
        calc_fps = f; calc_use_part = u; calc_total_part = t;
        st_fps = f; st_use = u; st_tot = t;
        hdr_fc = exp_frames;
        w_idx = 0;
        rd_start = 1'b1;
        @(posedge clk_200M);
        #1;
        rd_start = 1'b0;
        // Scramble the stats to prove the header was latched at acceptance.
        calc_fps = 32'hDEAD_0001; calc_use_part = 32'hDEAD_0002; calc_total_part = 32'hDEAD_0003;
        check(busy === 1'b1, "busy_on", 32'(busy), 32'd1);
        check(calc_res_ram_addr != PARK, "addr_unparked", 32'(calc_res_ram_addr), 32'd0);
    endtask

    task automatic wait_frame(input int limit);
        int n = 0;
        while (!(w_idx == FRAME_WORDS && !busy) && n < limit) begin
            @(posedge clk_200M);
            #1;
            n++;
        end
        check(n < limit, "frame_timeout", 32'(n), 32'(limit));
        check(w_idx == FRAME_WORDS, "word_count", 32'(w_idx), 32'(FRAME_WORDS));
        check(calc_res_ram_addr == PARK, "park_after", 32'(calc_res_ram_addr), 32'(PARK));
        check(frame_cnt == 16'(exp_frames), "frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check(m_tvalid === 1'b0, "empty_after", 32'(m_tvalid), 32'd0);
    endtask

    task automatic wait_word(input int target);
        int n = 0;
        while (w_idx < target && n < 5000) begin
            @(posedge clk_200M);
            #1;
            n++;
        end
        check(n < 5000, "word_timeout", 32'(w_idx), 32'(target));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got %0d words expected %0d", w_idx, FRAME_WORDS);
        $fatal(1);
    end

    initial begin
        // Reset state and quiet idle
        repeat (3) @(posedge clk_200M);
        #1;
        check(calc_res_ram_addr == PARK && m_tvalid === 1'b0 && busy === 1'b0 && frame_cnt == 16'd0,
              "reset_state", 32'(calc_res_ram_addr), 32'(PARK));
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk_200M);
            check(calc_res_ram_addr == PARK && m_tvalid === 1'b0 && busy === 1'b0 && frame_cnt == 16'd0,
                  "idle_quiet", 32'(calc_res_ram_addr), 32'(PARK));
        end
        mon_en = 1;

        // Full frame, ready held high
        rdy_mode = 1;
        start_frame(32'd5, 32'd7, 32'd9);
        wait_frame(5000);
        check(got[0] == 32'hCA1C_0000, "h0_lit", got[0], 32'hCA1C_0000);
        check(got[1] == 32'd5, "fps_lit", got[1], 32'd5);
        check(got[3] == 32'd9, "total_lit", got[3], 32'd9);
        check(got[4] == 32'h100, "first_data_lit", got[4], 32'h100);
        check(got[1003] == 32'h4E7, "last_data_lit", got[1003], 32'h4E7);
        check(frame_cnt == 16'd1, "frame_cnt_lit1", 32'(frame_cnt), 32'd1);

        // Random backpressure
        rdy_mode = 2;
        start_frame(32'd5, 32'd7, 32'd9);
        wait_frame(20000);
        check(got[0] == 32'hCA1C_0001, "h0_lit2", got[0], 32'hCA1C_0001);

        // Long stall right after start
        rdy_mode = 0;
        start_frame(32'd5, 32'd7, 32'd9);
        repeat (200) begin
            @(posedge clk_200M);
            #1;
        end
        check(m_tvalid === 1'b1, "stall_valid", 32'(m_tvalid), 32'd1);
        check(calc_res_ram_addr == 10'd0, "stall_addr_frozen", 32'(calc_res_ram_addr), 32'd0);
        check(m_tdata == 32'hCA1C_0002, "stall_head_lit", m_tdata, 32'hCA1C_0002);
        check(w_idx == 0, "stall_no_pop", 32'(w_idx), 32'd0);
        rdy_mode = 1;
        wait_frame(5000);

        // Rejected rd_start mid-frame
        check(overrun === 1'b0, "overrun_clear", 32'(overrun), 32'd0);
        start_frame(32'd11, 32'd13, 32'd17);
        wait_word(504);
        @(posedge clk_200M);
        #1;
        rd_start = 1'b1;
        @(posedge clk_200M);
        #1;
        rd_start = 1'b0;
        check(overrun === 1'b1, "overrun_set", 32'(overrun), 32'd1);
        wait_frame(5000);
        check(frame_cnt == 16'd4, "frame_cnt_lit4", 32'(frame_cnt), 32'd4);
        check(overrun === 1'b1, "overrun_sticky", 32'(overrun), 32'd1);

        // Asynchronous reset mid-frame
        start_frame(32'd5, 32'd7, 32'd9);
        wait_word(304);
        @(posedge clk_200M);
        #1;
        rst_n = 1'b0;
        #0.5;
        check(calc_res_ram_addr == PARK && m_tvalid === 1'b0 && m_tlast === 1'b0 && m_tdata == 32'd0 &&
              busy === 1'b0 && frame_cnt == 16'd0 && overrun === 1'b0,
              "async_reset", {frame_cnt, 6'd0, calc_res_ram_addr}, {16'd0, 6'd0, PARK});
        w_idx = 0;
        exp_frames = 0;
        repeat (3) @(posedge clk_200M);
        #1;
        rst_n = 1'b1;
        start_frame(32'd5, 32'd7, 32'd9);
        wait_frame(5000);
        check(got[0] == 32'hCA1C_0000, "h0_after_reset", got[0], 32'hCA1C_0000);
        check(frame_cnt == 16'd1, "frame_cnt_after_reset", 32'(frame_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
